divide_signed: RTL and testbench

//  Iterative radix-2 restoring divider; counterpart of the sequential multiplier in the M-extension datapath.

---
 rtl/divide_pkg.sv | 26 ++
 rtl/divide_step.sv | 26 ++
 rtl/divide_signed.sv | 109 ++++++++++
 tb/tb_divide_signed.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/divide_pkg.sv
// Shared types and helpers for the iterative signed/unsigned divider.
package divide_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Widest operand the magnitude helper supports.
  localparam int MAX_W = 64;
  localparam int MAX_IW = $clog2(MAX_W);

  // Magnitude of a w-bit value held zero-extended in a MAX_W-bit word.
  // Negation is mod 2^MAX_W; the caller truncates to w bits, which gives
  // the correct mod 2^w result (so |MIN| = 2^(w-1) is preserved).
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                             input int unsigned      w,
                                             input logic             sgn);
    logic neg;
    neg = sgn & value[MAX_IW'(w - 1)];
    if (neg) return (~value) + MAX_W'(1);
    else     return value;
  endfunction

endpackage

// File: rtl/divide_step.sv
// One restoring division step: shift in the next dividend bit, subtract the
// divisor when that does not borrow, and report the resulting quotient bit.
module divide_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic         next_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;
  logic         borrow;

  // Trial subtraction on a widened remainder; the top bit of diff is the borrow.
  always_comb begin
    shifted  = {rem, next_bit};
    diff     = shifted - {2'b00, divisor};
    borrow   = diff[W+1];
    q_bit    = ~borrow;
    rem_next = (W+1)'(borrow ? shifted : diff);
  end

endmodule

// File: rtl/divide_signed.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on magnitudes for W cycles, then applies the result signs in FIX.
// Divide-by-zero needs no special datapath: subtracting a zero divisor never
// borrows, so the raw quotient is all ones and the remainder is |a|; only the
// quotient sign fix is suppressed.
module divide_signed
  import divide_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sgn,
  input  logic         stb,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         ack
);

  localparam int CW = $clog2(W);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     rem_q;
  logic [W-1:0]   dvd_q;
  logic [W-1:0]   dvs_q;
  logic [W-1:0]   quot_q;
  logic           qneg_q;
  logic           rneg_q;
  logic           dz_q;
  logic [W-1:0]   q_q;
  logic [W-1:0]   r_q;
  logic           ack_q;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     rem_d;
  logic           qbit_d;

  // Operand magnitudes are only captured on the accepting edge.
  always_comb begin
    a_mag = W'(abs_w(MAX_W'(a), W, sgn));
    b_mag = W'(abs_w(MAX_W'(b), W, sgn));
  end

  divide_step #(.W(W)) u_step (
    .rem      (rem_q),
    .next_bit (dvd_q[W-1]),
    .divisor  (dvs_q),
    .rem_next (rem_d),
    .q_bit    (qbit_d)
  );

  // Control FSM, datapath registers and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stb) begin
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            qneg_q  <= sgn & (a[W-1] ^ b[W-1]);
            rneg_q  <= sgn & a[W-1];
            dz_q    <= (b == '0);
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q  <= rem_d;
          dvd_q  <= {dvd_q[W-2:0], 1'b0};
          quot_q <= {quot_q[W-2:0], qbit_d};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= FIX;
        end
        FIX: begin
          q_q     <= (qneg_q && !dz_q) ? -quot_q : quot_q;
          r_q     <= rneg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
          ack_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q   = q_q;
  assign r   = r_q;
  assign ack = ack_q;

endmodule

// File: tb/tb_divide_signed.sv
// Self-checking bench for divide_signed: directed corner cases, back-to-back
// handshake, reset mid-operation and randomized operands against a
// behavioural RISC-V division model.
module tb_divide_signed;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sgn = 1'b0;
  logic         stb = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         ack;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  divide_signed #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sgn (sgn),
    .stb (stb),
    .q   (q),
    .r   (r),
    .ack (ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics, straight from the arithmetic definitions.
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic s,
                                  output logic [W-1:0] eq, output logic [W-1:0] er);
    if (y == '0) begin
      eq = '1;
      er = x;
    end else if (s) begin
      if (x == MINV && y == '1) begin
        eq = MINV;
        er = '0;
      end else begin
        eq = W'($signed(x) / $signed(y));
        er = W'($signed(x) % $signed(y));
      end
    end else begin
      eq = x / y;
      er = x % y;
    end
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = W'(1);
      2:       v = '1;
      3:       v = MINV;
      4:       v = ~MINV;
      5:       v = W'($urandom_range(0, 15));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Issue one operation from a negedge with the DUT idle (or in its ack cycle)
  // and return at the negedge where ack is seen. With hold set, stb stays high
  // so the caller can chain the next op directly from the ack cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic ts, input bit hold);
    logic [W-1:0] eq, er;
    int lat;
    ref_div(ta, tb_v, ts, eq, er);
    a = ta; b = tb_v; sgn = ts; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    chk("ack_low_after_accept", 64'(ack), 64'(0));
    if (!hold) stb = 1'b0;
    a = W'($urandom); b = W'($urandom); sgn = 1'($urandom_range(0, 1));
    while (!ack && lat < W + 8) begin
      @(negedge clk);
      lat++;
      if (lat == 10) begin
        chk("q_held_during_run", 64'(q), 64'(prev_q));
        chk("r_held_during_run", 64'(r), 64'(prev_r));
      end
      if (!hold && lat == 8) stb = 1'b1;
      if (!hold && lat == 9) stb = 1'b0;
    end
    chk($sformatf("latency a=%h b=%h s=%0d", ta, tb_v, ts), 64'(lat), 64'(W + 1));
    chk($sformatf("q a=%h b=%h s=%0d", ta, tb_v, ts), 64'(q), 64'(eq));
    chk($sformatf("r a=%h b=%h s=%0d", ta, tb_v, ts), 64'(r), 64'(er));
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;
    #1 rst = 1'b1;
    #1;
    chk("reset_ack", 64'(ack), 64'(0));
    chk("reset_q", 64'(q), 64'(0));
    chk("reset_r", 64'(r), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    do_op(32'd20, 32'hFFFF_FFFD, 1'b1, 1'b0);
    chk("t1_q_const", 64'(q), 64'(32'hFFFF_FFFA));
    chk("t1_r_const", 64'(r), 64'(32'd2));
    do_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
    chk("t2_q_const", 64'(q), 64'(32'h0FFF_FFFF));
    do_op(32'd7, 32'd7, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
    chk("dz_signed_q_const", 64'(q), 64'(32'hFFFF_FFFF));
    chk("dz_signed_r_const", 64'(r), 64'(32'hFFFF_FFFB));
    do_op(32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
    do_op(MINV, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("ovf_q_const", 64'(q), 64'(MINV));
    chk("ovf_r_const", 64'(r), 64'(0));
    do_op(MINV, 32'd1, 1'b1, 1'b0);

    // Back-to-back with stb held and new operands presented at each ack.
    for (int k = 0; k < 5; k++)
      do_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
    stb = 1'b0;
    @(negedge clk);
    chk("ack_pulse_width", 64'(ack), 64'(0));

    // Randomized operands, both signednesses.
    for (int k = 0; k < 150; k++)
      do_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of an operation.
    do_op(32'd100, 32'd7, 1'b0, 1'b0);
    a = 32'd55; b = 32'd3; sgn = 1'b0; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset_ack", 64'(ack), 64'(0));
    chk("midrun_reset_q", 64'(q), 64'(0));
    chk("midrun_reset_r", 64'(r), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    prev_q = '0;
    prev_r = '0;
    n_ack = 0;
    repeat (2 * W + 4) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    chk("no_ack_after_reset", 64'(n_ack), 64'(0));
    do_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
    do_op(32'd1000, 32'd33, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
